instr_loader: RTL

Writer side of the 64-entry × 25-bit instruction store that the pipelined multimedia unit's IF stage reads by `pc`. The block accepts instruction words over a valid/ready stream, writes them sequentially from address 0, and counts them. When loading ends, it asserts `core_run` to release the pipeline. It also provides the combinational fetch read port that IF indexes with `pc`.

---
 rtl/instr_loader.sv | 103 ++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// Sequential loader and masked fetch port for the 64 x 25-bit instruction store.
// Optional LOADER_PARITY_EN adds an even-parity input that rejects corrupted words.
module instr_loader #(
  parameter int DEPTH = 64,
  parameter int IW    = 25,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          in_valid,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
`ifdef LOADER_PARITY_EN
  input  logic          in_parity,
`endif
  output logic          in_ready,
  input  logic [AW-1:0] fetch_pc,
  output logic [IW-1:0] fetch_instr,
  output logic [AW:0]   word_count,
  output logic          core_run,
  output logic          load_err
);

  typedef enum logic {LOAD = 1'b0, DONE = 1'b1} state_t;

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW:0]   word_count_q, word_count_d;
  logic          load_err_q, load_err_d;
  logic          xfer, parity_ok, wr_en;
  logic [AW:0]   count_inc;
  logic [IW-1:0] mem [DEPTH];

`ifdef LOADER_PARITY_EN
  assign parity_ok = ~(^{in_data, in_parity});
`else
  assign parity_ok = 1'b1;
`endif

  assign in_ready   = (state_q == LOAD);
  assign core_run   = (state_q == DONE);
  assign word_count = word_count_q;
  assign load_err   = load_err_q;
  assign xfer       = in_valid && in_ready;
  assign count_inc  = word_count_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    load_err_d   = load_err_q;
    wr_en        = 1'b0;
    if (restart) begin
      // restart beats a coincident transfer: nothing written or counted
      state_d      = LOAD;
      word_count_d = '0;
      load_err_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (xfer) begin
            if (parity_ok) begin
              wr_en        = 1'b1;
              word_count_d = count_inc;
              if (in_last || (count_inc == FULL)) state_d = DONE;
              if (!in_last && (count_inc == FULL)) load_err_d = 1'b1;
            end else begin
              load_err_d = 1'b1;
            end
          end
        end
        DONE: begin
          if (in_valid) load_err_d = 1'b1;
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LOAD;
      word_count_q <= '0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      load_err_q   <= load_err_d;
    end
  end

  // Store has no reset; the word_count mask below keeps stale or X entries hidden.
  always_ff @(posedge clk) begin
    if (wr_en) mem[word_count_q[AW-1:0]] <= in_data;
  end

  always_comb begin
    fetch_instr = '0;
    if ({1'b0, fetch_pc} < word_count_q) fetch_instr = mem[fetch_pc];
  end

endmodule
